// File: rtl/lsu_byte_serial_if.sv
`default_nettype none
// ============================================================================
// Module   : lsu_byte_serial_if
// Brief    : Request/response handshake plus byte-wide memory port of the LSU.
//            The master modport is the LSU; the slave modport is core + memory.
// Revision : 1.0  initial release
// ============================================================================
interface lsu_byte_serial_if #(
    parameter int ADDR_W = 8
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [2:0]        req_func3;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;

    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [7:0]        mem_wdata;
    logic [7:0]        mem_rdata;

    modport master (
        input  req_valid, req_we, req_func3, req_addr, req_wdata,
        output req_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        input  rsp_ready,
        output mem_addr, mem_re, mem_we, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        output req_valid, req_we, req_func3, req_addr, req_wdata,
        input  req_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        output rsp_ready,
        input  mem_addr, mem_re, mem_we, mem_wdata,
        output mem_rdata
    );
endinterface
`default_nettype wire

// File: rtl/lsu_byte_serial.sv
`default_nettype none
// ============================================================================
// Module   : lsu_byte_serial
// Brief    : Load/store unit executing each request as 1, 2 or 4 byte cycles.
//            Optional macro MISALIGN_TRAP_EN rejects misaligned h/w accesses.
// Revision : 1.0  initial release
// ============================================================================
module lsu_byte_serial #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    lsu_byte_serial_if.master bus
);

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        r_k;
    logic              r_we;
    logic [2:0]        r_func3;
    logic [ADDR_W-1:0] r_addr;
    logic [31:0]       r_wdata;
    logic [31:0]       r_asm;
    logic [ADDR_W-1:0] r_last_addr;
    logic              r_err;

    logic [1:0]        w_last_k;
    logic [ADDR_W-1:0] w_cur_addr;
    logic              w_in_access;
    logic              w_in_resp;
    logic              w_misalign;
    logic [31:0]       w_ext;

    // Last byte index is N-1; funct3 3, 6 and 7 fall into the word case.
    always_comb begin
        w_last_k = 2'd3;
        case (r_func3[1:0])
            2'b00:   w_last_k = 2'd0;
            2'b01:   w_last_k = 2'd1;
            default: w_last_k = 2'd3;
        endcase
    end

    assign w_cur_addr  = r_addr + ADDR_W'(r_k);
    assign w_in_access = (r_state == c_ST_ACCESS);
    assign w_in_resp   = (r_state == c_ST_RESP);

`ifdef MISALIGN_TRAP_EN
    assign w_misalign = ((bus.req_func3[1:0] == 2'b01) && bus.req_addr[0]) ||
                        (bus.req_func3[1] && (bus.req_addr[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_k         <= 2'd0;
            r_we        <= 1'b0;
            r_func3     <= 3'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_asm       <= 32'd0;
            r_last_addr <= '0;
            r_err       <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_func3 <= bus.req_func3;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_k     <= 2'd0;
                        r_asm   <= 32'd0;
                        r_err   <= w_misalign;
                        r_state <= w_misalign ? c_ST_RESP : c_ST_ACCESS;
                    end
                end
                c_ST_ACCESS: begin
                    r_last_addr <= w_cur_addr;
                    if (!r_we) begin
                        r_asm[{r_k, 3'b000} +: 8] <= bus.mem_rdata;
                    end
                    if (r_k == w_last_k) begin
                        r_state <= c_ST_RESP;
                    end else begin
                        r_k <= r_k + 2'd1;
                    end
                end
                c_ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_state <= c_ST_IDLE;
                    end
                end
                default: r_state <= c_ST_IDLE;
            endcase
        end
    end

    // Little-endian assembly is already in place; only the upper bits differ.
    always_comb begin
        w_ext = r_asm;
        case (r_func3[1:0])
            2'b00:   w_ext = r_func3[2] ? {24'd0, r_asm[7:0]}
                                        : {{24{r_asm[7]}}, r_asm[7:0]};
            2'b01:   w_ext = r_func3[2] ? {16'd0, r_asm[15:0]}
                                        : {{16{r_asm[15]}}, r_asm[15:0]};
            default: w_ext = r_asm;
        endcase
    end

    assign bus.req_ready = (r_state == c_ST_IDLE);
    assign bus.rsp_valid = w_in_resp;
    assign bus.rsp_rdata = (w_in_resp && !r_we && !r_err) ? w_ext : 32'd0;
    assign bus.rsp_err   = w_in_resp && r_err;

    assign bus.mem_addr  = w_in_access ? w_cur_addr : r_last_addr;
    assign bus.mem_re    = w_in_access && !r_we;
    assign bus.mem_we    = w_in_access && r_we;
    assign bus.mem_wdata = (w_in_access && r_we) ? r_wdata[{r_k, 3'b000} +: 8] : 8'd0;

endmodule
`default_nettype wire

// File: tb/tb_lsu_byte_serial.sv
`default_nettype none
// Self-checking bench for lsu_byte_serial: directed scenarios plus randomized
// traffic compared against a byte-array memory model.
module tb_lsu_byte_serial;
    localparam int ADDR_W = 8;
`ifdef MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    lsu_byte_serial_if #(.ADDR_W(ADDR_W)) bus ();
    lsu_byte_serial #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Device memory (bench-owned) and the reference model's view of it
    logic [7:0] mem     [0:255];
    logic [7:0] ref_mem [0:255];
    logic       poke_en;
    logic [7:0] poke_addr, poke_data;

    assign bus.mem_rdata = mem[bus.mem_addr];
    always @(posedge clk) begin
        if (poke_en) mem[poke_addr] <= poke_data;
        else if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
    end

    logic       log_re [0:7];
    logic       log_we [0:7];
    logic [7:0] log_addr [0:7];
    logic [7:0] log_wd [0:7];

    function automatic int nbytes(input logic [2:0] f3);
        if (f3[1:0] == 2'b00) return 1;
        if (f3[1:0] == 2'b01) return 2;
        return 4;
    endfunction

    function automatic bit traps(input logic [2:0] f3, input logic [7:0] a);
        bit mis;
        mis = (nbytes(f3) == 2 && a % 2 != 0) || (nbytes(f3) == 4 && a % 4 != 0);
        return TRAP && mis;
    endfunction

    function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [7:0] a);
        int          n;
        logic [31:0] v;
        n = nbytes(f3);
        v = 32'd0;
        for (int i = 0; i < n; i++) v = v | (32'(ref_mem[8'(a + i)]) << (8 * i));
        if (n < 4 && !f3[2] && v[8 * n - 1]) v = v | (32'hFFFF_FFFF << (8 * n));
        return v;
    endfunction

    task automatic poke(input logic [7:0] a, input logic [7:0] d);
        poke_en = 1'b1; poke_addr = a; poke_data = d;
        ref_mem[a] = d;
        @(posedge clk); #1;
        poke_en = 1'b0;
    endtask

    task automatic issue_req(input logic we, input logic [2:0] f3, input logic [7:0] a,
                             input logic [31:0] wd, output int ncyc, output int t_acc,
                             output logic idle_strobe, output logic timeout);
        int g;
        g = 0;
        while (bus.req_ready !== 1'b1 && g < 20) begin @(posedge clk); #1; g++; end
        bus.req_valid = 1'b1; bus.req_we = we; bus.req_func3 = f3;
        bus.req_addr = a; bus.req_wdata = wd;
        @(posedge clk); #1;
        t_acc = cyc;
        bus.req_valid = 1'b0;
        ncyc = 0; timeout = 1'b0;
        while (bus.rsp_valid !== 1'b1) begin
            if (ncyc < 8) begin
                log_re[ncyc] = bus.mem_re; log_we[ncyc] = bus.mem_we;
                log_addr[ncyc] = bus.mem_addr; log_wd[ncyc] = bus.mem_wdata;
            end
            ncyc++;
            if (ncyc > 12) begin timeout = 1'b1; break; end
            @(posedge clk); #1;
        end
        idle_strobe = bus.mem_re | bus.mem_we | (|bus.mem_wdata);
    endtask

    task automatic take_rsp(output logic [31:0] rd, output logic err);
        rd = bus.rsp_rdata; err = bus.rsp_err;
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        n_total++;
        if (bus.req_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            $display("FAIL reset_handshake: req_ready=%b rsp_valid=%b, want 1 0", bus.req_ready, bus.rsp_valid);
        end else n_pass++;
        n_total++;
        if (bus.rsp_rdata !== 32'd0 || bus.rsp_err !== 1'b0) begin
            $display("FAIL reset_rsp: rdata=%h err=%b, want 0 0", bus.rsp_rdata, bus.rsp_err);
        end else n_pass++;
        n_total++;
        if (bus.mem_re !== 1'b0 || bus.mem_we !== 1'b0) begin
            $display("FAIL reset_strobes: re=%b we=%b, want 0 0", bus.mem_re, bus.mem_we);
        end else n_pass++;
        n_total++;
        if (bus.mem_addr !== 8'd0 || bus.mem_wdata !== 8'd0) begin
            $display("FAIL reset_mem: addr=%h wdata=%h, want 00 00", bus.mem_addr, bus.mem_wdata);
        end else n_pass++;
    endtask

    task automatic test_store();
        logic [7:0]  exp_b [0:3];
        int          ncyc, t_acc;
        logic        idl, to, err;
        logic [31:0] rd;
        exp_b[0] = 8'hEF; exp_b[1] = 8'hBE; exp_b[2] = 8'hAD; exp_b[3] = 8'hDE;
        issue_req(1'b1, 3'd2, 8'h10, 32'hDEADBEEF, ncyc, t_acc, idl, to);
        n_total++;
        if (ncyc !== 4 || to) $display("FAIL sw_latency: access cycles=%0d, want 4", ncyc);
        else n_pass++;
        for (int i = 0; i < 4; i++) begin
            n_total++;
            if (log_we[i] !== 1'b1 || log_re[i] !== 1'b0 || log_addr[i] !== 8'(8'h10 + i) || log_wd[i] !== exp_b[i])
                $display("FAIL sw_byte%0d: we=%b re=%b addr=%h wd=%h, want we=1 re=0 addr=%h wd=%h",
                         i, log_we[i], log_re[i], log_addr[i], log_wd[i], 8'(8'h10 + i), exp_b[i]);
            else n_pass++;
        end
        take_rsp(rd, err);
        n_total++;
        if (rd !== 32'd0 || err !== 1'b0) $display("FAIL sw_rsp: rdata=%h err=%b, want 0 0", rd, err);
        else n_pass++;
        for (int i = 0; i < 4; i++) ref_mem[8'(8'h10 + i)] = exp_b[i];
        n_total++;
        if (mem[8'h13] !== 8'hDE || mem[8'h10] !== 8'hEF)
            $display("FAIL sw_memory: [10]=%h [13]=%h, want EF DE", mem[8'h10], mem[8'h13]);
        else n_pass++;
    endtask

    task automatic test_load_ext();
        logic [2:0]  f3s  [0:3];
        logic [7:0]  adrs [0:3];
        logic [31:0] exps [0:3];
        int          ncyc, t_acc;
        logic        idl, to, err;
        logic [31:0] rd;
        f3s[0] = 3'd0; adrs[0] = 8'h20; exps[0] = 32'hFFFFFF80;
        f3s[1] = 3'd4; adrs[1] = 8'h20; exps[1] = 32'h00000080;
        f3s[2] = 3'd1; adrs[2] = 8'h30; exps[2] = 32'hFFFFF234;
        f3s[3] = 3'd5; adrs[3] = 8'h30; exps[3] = 32'h0000F234;
        poke(8'h20, 8'h80); poke(8'h30, 8'h34); poke(8'h31, 8'hF2);
        for (int t = 0; t < 4; t++) begin
            issue_req(1'b0, f3s[t], adrs[t], $urandom, ncyc, t_acc, idl, to);
            take_rsp(rd, err);
            n_total++;
            if (rd !== exps[t]) $display("FAIL load_ext[%0d]: rdata=%h, want %h", t, rd, exps[t]);
            else n_pass++;
            n_total++;
            if (ncyc !== nbytes(f3s[t]) || to || log_re[0] !== 1'b1)
                $display("FAIL load_cycles[%0d]: cycles=%0d re=%b, want %0d 1", t, ncyc, log_re[0], nbytes(f3s[t]));
            else n_pass++;
        end
    endtask

    task automatic test_wrap();
        int          ncyc, t_acc;
        logic        idl, to, err;
        logic [31:0] rd, exp;
        logic        bad;
        poke(8'hFE, 8'h11); poke(8'hFF, 8'h22); poke(8'h00, 8'h33); poke(8'h01, 8'h44);
        exp = traps(3'd2, 8'hFE) ? 32'd0 : model_load(3'd2, 8'hFE);
        issue_req(1'b0, 3'd2, 8'hFE, 32'd0, ncyc, t_acc, idl, to);
        take_rsp(rd, err);
        n_total++;
        if (rd !== exp || err !== TRAP) $display("FAIL wrap_rsp: rdata=%h err=%b, want %h %b", rd, err, exp, TRAP);
        else n_pass++;
        bad = (ncyc !== (TRAP ? 0 : 4)) || to;
        for (int i = 0; i < 4; i++) if (!TRAP && log_addr[i] !== 8'(8'hFE + i)) bad = 1'b1;
        n_total++;
        if (bad) $display("FAIL wrap_addr: cycles=%0d addr0=%h addr3=%h, want %0d FE 01",
                          ncyc, log_addr[0], log_addr[3], TRAP ? 0 : 4);
        else n_pass++;
    endtask

    task automatic test_random();
        int          ncyc, t_acc, n, nexp, bad_i, mism;
        logic        idl, to, err, we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] wd, rd, exp;
        for (int t = 0; t < 40; t++) begin
            we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7));
            a = 8'($urandom); wd = $urandom;
            n = nbytes(f3);
            nexp = traps(f3, a) ? 0 : n;
            exp = (we || traps(f3, a)) ? 32'd0 : model_load(f3, a);
            issue_req(we, f3, a, wd, ncyc, t_acc, idl, to);
            take_rsp(rd, err);
            n_total++;
            if (ncyc !== nexp || to) $display("FAIL rand_latency[%0d]: cycles=%0d, want %0d", t, ncyc, nexp);
            else n_pass++;
            bad_i = -1;
            for (int i = 0; i < nexp; i++)
                if (bad_i < 0 && (log_addr[i] !== 8'(a + i) || log_we[i] !== we || log_re[i] !== !we ||
                                  log_wd[i] !== (we ? wd[8 * i +: 8] : log_wd[i])))
                    bad_i = i;
            n_total++;
            if (bad_i >= 0)
                $display("FAIL rand_strobe[%0d] byte %0d: addr=%h we=%b wd=%h, want addr=%h we=%b wd=%h", t, bad_i,
                         log_addr[bad_i], log_we[bad_i], log_wd[bad_i], 8'(a + bad_i), we, wd[8 * bad_i +: 8]);
            else n_pass++;
            n_total++;
            if (rd !== exp || err !== traps(f3, a) || idl !== 1'b0)
                $display("FAIL rand_rsp[%0d]: rdata=%h err=%b strobe_in_resp=%b, want %h %b 0",
                         t, rd, err, idl, exp, traps(f3, a));
            else n_pass++;
            if (we && !traps(f3, a)) for (int i = 0; i < n; i++) ref_mem[8'(a + i)] = wd[8 * i +: 8];
        end
        mism = 0;
        for (int i = 0; i < 256; i++) if (mem[i] !== ref_mem[i]) mism++;
        n_total++;
        if (mism != 0) $display("FAIL rand_memory: %0d differing bytes, want 0", mism);
        else n_pass++;
    endtask

    task automatic test_backpressure();
        int          ncyc, t_acc;
        logic        idl, to, err, bad;
        logic [7:0]  a;
        logic [31:0] rd, exp;
        a = 8'($urandom) & 8'hFC;
        exp = model_load(3'd2, a);
        issue_req(1'b0, 3'd2, a, 32'd0, ncyc, t_acc, idl, to);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_func3 = 3'd0;
        bus.req_addr = 8'($urandom); bus.req_wdata = $urandom;
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== exp || bus.req_ready !== 1'b0 ||
                bus.mem_we !== 1'b0 || bus.mem_re !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL hold_stable: rsp_valid=%b rdata=%h req_ready=%b, want 1 %h 0",
                          bus.rsp_valid, bus.rsp_rdata, bus.req_ready, exp);
        else n_pass++;
        bus.req_valid = 1'b0;
        take_rsp(rd, err);
        n_total++;
        if (rd !== exp) $display("FAIL hold_rdata: rdata=%h, want %h", rd, exp);
        else n_pass++;
        @(posedge clk); #1;
        n_total++;
        if (bus.req_ready !== 1'b1 || bus.mem_we !== 1'b0 || bus.rsp_valid !== 1'b0)
            $display("FAIL hold_no_accept: req_ready=%b mem_we=%b rsp_valid=%b, want 1 0 0",
                     bus.req_ready, bus.mem_we, bus.rsp_valid);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [31:0] wd;
        logic        bad;
        int          mism;
        wd = $urandom;
        for (int i = 0; i < 4; i++) poke(8'(8'h40 + i), ~wd[8 * i +: 8]);
        bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_func3 = 3'd2;
        bus.req_addr = 8'h40; bus.req_wdata = wd;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_total++;
        if (bus.mem_we !== 1'b1 || bus.mem_addr !== 8'h42)
            $display("FAIL rstmid_third_byte: we=%b addr=%h, want 1 42", bus.mem_we, bus.mem_addr);
        else n_pass++;
        rst = 1'b1;
        #1;
        n_total++;
        if (bus.mem_we !== 1'b0 || bus.mem_addr !== 8'd0 || bus.mem_wdata !== 8'd0 || bus.req_ready !== 1'b1)
            $display("FAIL rstmid_outputs: we=%b addr=%h wd=%h req_ready=%b, want 0 00 00 1",
                     bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.req_ready);
        else n_pass++;
        @(posedge clk); #1;
        rst = 1'b0;
        ref_mem[8'h40] = wd[7:0]; ref_mem[8'h41] = wd[15:8];
        bad = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            if (bus.rsp_valid !== 1'b0) bad = 1'b1;
        end
        n_total++;
        if (bad) $display("FAIL rstmid_no_rsp: rsp_valid seen=%b, want 0", bad);
        else n_pass++;
        mism = 0;
        for (int i = 0; i < 4; i++) if (mem[8'(8'h40 + i)] !== ref_mem[8'(8'h40 + i)]) mism++;
        n_total++;
        if (mism != 0) $display("FAIL rstmid_memory: bytes %h %h %h %h, want %h %h %h %h",
                                mem[8'h40], mem[8'h41], mem[8'h42], mem[8'h43],
                                ref_mem[8'h40], ref_mem[8'h41], ref_mem[8'h42], ref_mem[8'h43]);
        else n_pass++;
    endtask

    task automatic test_back_to_back();
        int          ncyc, t_acc, prev_acc, prev_gap;
        logic        idl, to, err, we;
        logic [2:0]  f3;
        logic [7:0]  a;
        logic [31:0] rd;
        prev_acc = -1; prev_gap = 0;
        for (int t = 0; t < 8; t++) begin
            we = 1'($urandom_range(0, 1)); f3 = 3'($urandom_range(0, 7)); a = 8'($urandom);
            issue_req(we, f3, a, $urandom, ncyc, t_acc, idl, to);
            if (prev_acc >= 0) begin
                n_total++;
                if (t_acc - prev_acc !== prev_gap)
                    $display("FAIL b2b_gap[%0d]: accept-to-accept=%0d, want %0d", t, t_acc - prev_acc, prev_gap);
                else n_pass++;
            end
            prev_acc = t_acc;
            prev_gap = (traps(f3, a) ? 0 : nbytes(f3)) + 2;
            take_rsp(rd, err);
            if (we && !traps(f3, a)) for (int i = 0; i < nbytes(f3); i++) ref_mem[8'(a + i)] = mem[8'(a + i)];
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; poke_en = 1'b0; poke_addr = 8'd0; poke_data = 8'd0;
        bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_func3 = 3'd0;
        bus.req_addr = 8'd0; bus.req_wdata = 32'd0; bus.rsp_ready = 1'b0;
        for (int i = 0; i < 256; i++) poke(8'(i), 8'($urandom));
        test_reset();
        rst = 1'b0;
        @(posedge clk); #1;
        test_store();
        test_load_ext();
        test_wrap();
        test_random();
        test_backpressure();
        test_reset_mid();
        test_back_to_back();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
`default_nettype wire
